// File: rtl/mnist_pixel_packer_pkg.sv
// Shared geometry constants and FSM state type for the MNIST pixel packer.
package mnist_pixel_packer_pkg;

  localparam int unsigned IMG_DIM  = 28;
  localparam int unsigned POOL     = 4;
  localparam int unsigned OUT_DIM  = 7;
  localparam int unsigned OUT_BITS = 49;
  localparam int unsigned POS_W    = 5;   // holds 0..IMG_DIM-1
  localparam int unsigned ACC_W    = 5;   // holds 0..POOL*POOL

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/mnist_pool_row.sv
// Seven per-block-column hit accumulators for one 4-pixel band of rows.
// Produces the 7-bit block-row vector including the current pixel.
module mnist_pool_row
  import mnist_pixel_packer_pkg::*;
#(
  parameter int unsigned MIN_HITS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en_i,
  input  logic               restart_i,
  input  logic               hit_i,
  input  logic [2:0]         blk_col_i,
  input  logic               row_end_i,
  output logic [OUT_DIM-1:0] row_bits_o
);

  localparam logic [ACC_W-1:0] MIN_C = ACC_W'(MIN_HITS);

  logic [ACC_W-1:0] acc_q [OUT_DIM];
  logic [ACC_W-1:0] acc_d [OUT_DIM];
  logic [ACC_W-1:0] cnt   [OUT_DIM];

  // Count including this pixel; a restart treats prior counts as zero.
  always_comb begin
    row_bits_o = '0;
    for (int unsigned i = 0; i < OUT_DIM; i++) begin
      cnt[i]        = (restart_i ? '0 : acc_q[i])
                    + {{(ACC_W-1){1'b0}}, hit_i & (blk_col_i == 3'(i))};
      row_bits_o[i] = (cnt[i] >= MIN_C);
      acc_d[i]      = acc_q[i];
      if (pix_en_i) acc_d[i] = row_end_i ? '0 : cnt[i];
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < OUT_DIM; i++) acc_q[i] <= acc_d[i];
    end
  end

endmodule

// File: rtl/mnist_pixel_packer.sv
// Binarizes a 28x28 grayscale raster, pools into 4x4 blocks and emits a
// 49-bit 7x7 frame through a single-entry valid/ready output register.
module mnist_pixel_packer
  import mnist_pixel_packer_pkg::*;
#(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned THRESH   = 128,
  parameter int unsigned MIN_HITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [PIX_W-1:0]    pix_data,
  input  logic                pix_sof,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic [OUT_BITS-1:0] frame_bits,
  output logic                sof_err,
  output logic [15:0]         drop_cnt
);

  localparam logic [PIX_W-1:0] THRESH_C = PIX_W'(THRESH);
  localparam logic [POS_W-1:0] LAST     = POS_W'(IMG_DIM - 1);

  state_e              state_q, state_d;
  logic [POS_W-1:0]    col_q, col_d, row_q, row_d;
  logic [OUT_BITS-1:0] work_q, work_d, fbits_q, fbits_d;
  logic                fvalid_q, fvalid_d, sof_err_q, sof_err_d;
  logic [15:0]         drop_q, drop_d;

  logic                accept, restart, pix_en, row_end, last_pix;
  logic                out_free, handshake;
  logic [POS_W-1:0]    pos_col, pos_row;
  logic [OUT_DIM-1:0]  row_bits;
  logic [OUT_BITS-1:0] work_full;

  // Accepted pixel decode; an accepted sof always relocates the pixel to (0,0).
  always_comb begin
    accept    = pix_valid & (state_q != ST_HOLD);
    restart   = accept & pix_sof;
    pix_en    = accept & (pix_sof | (state_q == ST_COLLECT));
    pos_col   = pix_sof ? '0 : col_q;
    pos_row   = pix_sof ? '0 : row_q;
    row_end   = pix_en & (pos_col == LAST) & (pos_row[1:0] == 2'd3);
    last_pix  = pix_en & (pos_col == LAST) & (pos_row == LAST);
    out_free  = ~fvalid_q | frame_ready;
    handshake = fvalid_q & frame_ready;
  end

  mnist_pool_row #(
    .MIN_HITS (MIN_HITS)
  ) u_pool_row (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en_i   (pix_en),
    .restart_i  (restart),
    .hit_i      (pix_data >= THRESH_C),
    .blk_col_i  (pos_col[4:2]),
    .row_end_i  (row_end),
    .row_bits_o (row_bits)
  );

  // Work bits as they stand after this pixel, so the last row is visible immediately.
  always_comb begin
    work_full = restart ? '0 : work_q;
    if (row_end) begin
      for (int unsigned b = 0; b < OUT_DIM; b++) begin
        if (pos_row[4:2] == 3'(b)) work_full[b*OUT_DIM +: OUT_DIM] = row_bits;
      end
    end
  end

  // Next-state, counters, work bits and output register.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    work_d    = work_q;
    fbits_d   = fbits_q;
    fvalid_d  = fvalid_q & ~handshake;
    sof_err_d = restart & (state_q == ST_COLLECT);
    drop_d    = drop_q;

    if (accept && !pix_sof && state_q == ST_IDLE && drop_q != '1) drop_d = drop_q + 16'd1;

    if (pix_en) begin
      work_d = work_full;
      if (pos_col == LAST) begin
        col_d = '0;
        row_d = (pos_row == LAST) ? '0 : pos_row + POS_W'(1);
      end else begin
        col_d = pos_col + POS_W'(1);
        row_d = pos_row;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (restart) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (last_pix) begin
          if (out_free) begin
            fbits_d  = work_full;
            fvalid_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          fbits_d  = work_q;
          fvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      work_q    <= '0;
      fbits_q   <= '0;
      fvalid_q  <= 1'b0;
      sof_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      work_q    <= work_d;
      fbits_q   <= fbits_d;
      fvalid_q  <= fvalid_d;
      sof_err_q <= sof_err_d;
      drop_q    <= drop_d;
    end
  end

  assign pix_ready   = (state_q != ST_HOLD);
  assign frame_valid = fvalid_q;
  assign frame_bits  = fbits_q;
  assign sof_err     = sof_err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_mnist_pixel_packer.sv
// Directed + randomized bench for mnist_pixel_packer with a whole-frame reference model.
module tb_mnist_pixel_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic        frame_ready = 1'b0;
  logic [7:0]  pix_data = '0;

  logic        pix_ready, frame_valid, sof_err;
  logic [48:0] frame_bits;
  logic [15:0] drop_cnt;
  logic        pix_ready2, frame_valid2, sof_err2;
  logic [48:0] frame_bits2;
  logic [15:0] drop_cnt2;

  int tests = 0;
  int fails = 0;
  int img [784];
  logic [48:0] exp_a, exp_b, exp_b2;

  always #5 clk = ~clk;

  mnist_pixel_packer #(.PIX_W(8), .THRESH(128), .MIN_HITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_bits(frame_bits), .sof_err(sof_err),
    .drop_cnt(drop_cnt)
  );

  mnist_pixel_packer #(.PIX_W(8), .THRESH(128), .MIN_HITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready2),
    .pix_data(pix_data), .pix_sof(pix_sof), .frame_valid(frame_valid2),
    .frame_ready(frame_ready), .frame_bits(frame_bits2), .sof_err(sof_err2),
    .drop_cnt(drop_cnt2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-frame reference: count hits per 4x4 block, compare against the minimum.
  function automatic logic [48:0] model(input int min_hits);
    int cnt [49];
    logic [48:0] r;
    r = '0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int p = 0; p < 784; p++)
      if (img[p] >= 128) cnt[((p / 28) / 4) * 7 + (p % 28) / 4]++;
    for (int b = 0; b < 49; b++) if (cnt[b] >= min_hits) r[b] = 1'b1;
    return r;
  endfunction

  // Present one pixel at a negedge; returns at the negedge after it is accepted.
  task automatic push(input int d, input logic s);
    int n;
    n = 0;
    pix_valid = 1'b1;
    pix_data  = 8'(d);
    pix_sof   = s;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("push_ready_timeout", 64'(pix_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int p = from; p < to; p++) push(img[p], p == 0);
  endtask

  task automatic fill_const(input int v);
    for (int p = 0; p < 784; p++) img[p] = v;
  endtask

  task automatic fill_rand(input int density);
    for (int p = 0; p < 784; p++)
      img[p] = ($urandom_range(99) < density) ? int'($urandom_range(255, 128))
                                              : int'($urandom_range(127, 0));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_frame_bits", 64'(frame_bits), 64'd0);
    check("rst_sof_err", 64'(sof_err), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pix_ready", 64'(pix_ready), 64'd1);

    // Pixels before any sof are dropped
    for (int i = 0; i < 5; i++) push(int'($urandom_range(255)), 1'b0);
    check("drop_cnt_5", 64'(drop_cnt), 64'd5);
    check("drop_still_idle", 64'(pix_ready), 64'd1);
    check("drop_no_frame", 64'(frame_valid), 64'd0);

    frame_ready = 1'b1;

    // All-255 and all-0 frames, streamed back to back
    fill_const(255);
    send_range(0, 784);
    check("ones_valid", 64'(frame_valid), 64'd1);
    check("ones_bits", 64'(frame_bits), 64'h1FFFFFFFFFFFF);
    check("ones_bits_min2", 64'(frame_bits2), 64'h1FFFFFFFFFFFF);
    fill_const(0);
    send_range(0, 784);
    check("zeros_valid", 64'(frame_valid), 64'd1);
    check("zeros_bits", 64'(frame_bits), 64'd0);

    // Single hit at bottom-left corner
    fill_const(0);
    img[27 * 28] = 200;
    send_range(0, 784);
    check("corner_bits_min1", 64'(frame_bits), 64'h1 << 42);
    check("corner_bits_min2", 64'(frame_bits2), 64'd0);

    // Random frames, streamed
    for (int f = 0; f < 4; f++) begin
      fill_rand(5 + 8 * f);
      send_range(0, 784);
      check("rand_valid", 64'(frame_valid), 64'd1);
      check("rand_bits_min1", 64'(frame_bits), 64'(model(1)));
      check("rand_bits_min2", 64'(frame_bits2), 64'(model(2)));
    end
    @(negedge clk);
    check("drained_valid", 64'(frame_valid), 64'd0);

    // Backpressure through two frames
    frame_ready = 1'b0;
    fill_rand(10);
    exp_a = model(1);
    send_range(0, 784);
    check("bp_first_valid", 64'(frame_valid), 64'd1);
    check("bp_first_bits", 64'(frame_bits), 64'(exp_a));
    fill_rand(10);
    exp_b  = model(1);
    exp_b2 = model(2);
    send_range(0, 784);
    check("bp_hold_ready", 64'(pix_ready), 64'd0);
    check("bp_hold_bits", 64'(frame_bits), 64'(exp_a));
    repeat (2) @(negedge clk);
    check("bp_hold_ready_later", 64'(pix_ready), 64'd0);
    check("bp_hold_bits_later", 64'(frame_bits), 64'(exp_a));
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_second_valid", 64'(frame_valid), 64'd1);
    check("bp_second_bits", 64'(frame_bits), 64'(exp_b));
    check("bp_second_bits_min2", 64'(frame_bits2), 64'(exp_b2));
    check("bp_back_idle", 64'(pix_ready), 64'd1);
    @(negedge clk);
    check("bp_drained", 64'(frame_valid), 64'd0);

    // Mid-frame sof at pixel 300 and at pixel (27,27)
    foreach (exp_a[k]) exp_a[k] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      fill_rand(20);
      send_range(0, (t == 0) ? 300 : 783);
      check("abort_no_frame", 64'(frame_valid), 64'd0);
      fill_rand(15);
      push(img[0], 1'b1);
      check("abort_sof_err", 64'(sof_err), 64'd1);
      send_range(1, 783);
      check("abort_sof_err_cleared", 64'(sof_err), 64'd0);
      check("abort_still_no_frame", 64'(frame_valid), 64'd0);
      push(img[783], 1'b0);
      check("abort_new_valid", 64'(frame_valid), 64'd1);
      check("abort_new_bits", 64'(frame_bits), 64'(model(1)));
    end

    check("drop_cnt_kept", 64'(drop_cnt), 64'd5);

    // Reset in the middle of a frame
    fill_rand(20);
    send_range(0, 500);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(frame_valid), 64'd0);
    check("midrst_bits", 64'(frame_bits), 64'd0);
    check("midrst_sof_err", 64'(sof_err), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 64'(pix_ready), 64'd1);
    fill_rand(12);
    send_range(0, 784);
    check("postrst_valid", 64'(frame_valid), 64'd1);
    check("postrst_bits", 64'(frame_bits), 64'(model(1)));
    check("postrst_bits_min2", 64'(frame_bits2), 64'(model(2)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mnist_pixel_packer.md
MNIST_PIXEL_PACKER -- requirements
Module: mnist_pixel_packer

Interface
REQ-001 Parameter PIX_W, 8, grayscale pixel width.
REQ-002 Parameter THRESH, 128, binarization threshold; pixel hit = pix_data >= THRESH, unsigned.
REQ-003 Parameter MIN_HITS, 1, block bit = 1 when hits in a 4x4 block >= MIN_HITS; legal range 1..16.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 pix_valid  input  1  pixel offered.
REQ-007 pix_ready  output  1  pixel accepted when pix_valid & pix_ready.
REQ-008 pix_data  input  PIX_W  pixel value, 28x28 raster order, row-major.
REQ-009 pix_sof  input  1  marks pixel (0,0) of a frame; qualified by pix_valid.
REQ-010 frame_valid  output  1  frame_bits holds a complete 7x7 frame.
REQ-011 frame_ready  input  1  consumer (gate network wrapper) takes frame when frame_valid & frame_ready.
REQ-012 frame_bits  output  49  packed frame; bit index = block_row*7 + block_col, bit 0 = top-left.
REQ-013 sof_err  output  1  one-cycle pulse when pix_sof is accepted mid-frame.
REQ-014 drop_cnt  output  16  saturating count of pixels discarded while waiting for pix_sof.

Function
REQ-015 States: IDLE (await sof), COLLECT (assembling), HOLD (frame complete, output register occupied).
REQ-016 pix_ready = 1 in IDLE and COLLECT, 0 in HOLD.
REQ-017 IDLE: accepted pixel with pix_sof=0 is discarded and drop_cnt increments, saturating at 16'hFFFF; accepted pixel with pix_sof=1 is pixel (0,0), state -> COLLECT.
REQ-018 Column counter 0..27 and row counter 0..27 advance per accepted pixel; col wraps 27->0 with row increment.
REQ-019 Seven 5-bit hit accumulators, one per block column; accumulator[col/4] increments on each hit pixel.
REQ-020 At accepted pixel with row%4==3 and col==27: work bits [block_row*7 +: 7] <= (acc[i] including this pixel) >= MIN_HITS; all accumulators clear.
REQ-021 At pixel (27,27): if output register empty or being drained this cycle, copy work bits to frame_bits, set frame_valid next cycle, state -> IDLE; else state -> HOLD.
REQ-022 HOLD: when frame_valid & frame_ready, frame_bits <= work bits, frame_valid stays 1, state -> IDLE.
REQ-023 frame_valid clears on handshake unless a new frame is loaded in the same cycle; frame_bits stable while frame_valid=1 and frame_ready=0.
REQ-024 Latency: last pixel accept at cycle N -> frame_valid=1 at cycle N+1 when output register is free.
REQ-025 pix_sof accepted in COLLECT at any position other than (0,0): sof_err pulses next cycle, counters, accumulators and work bits clear, that pixel is processed as (0,0).
REQ-026 pix_sof on pixel (27,27) in COLLECT: treated per REQ-025 (frame restarted, no output).
REQ-027 Back-to-back frames with frame_ready=1 SHALL stream at one pixel per cycle with no bubbles.

Reset
REQ-028 rst_n low: state IDLE, counters 0, accumulators 0, work bits 0, frame_bits 0, frame_valid 0, sof_err 0, drop_cnt 0; pix_ready 1 after deassertion.
REQ-029 Reset mid-frame or in HOLD discards partial and pending frames; no frame_valid until a full new frame completes.

Structure
REQ-030 Shared package holds IMG_DIM=28, POOL=4, OUT_DIM=7, OUT_BITS=49 and the state enum.
REQ-031 One sub-module, mnist_pool_row, holds the seven accumulators and produces the 7-bit block-row vector; counters, FSM and output register stay in the top.

Verification
REQ-032 All 784 pixels = 255, frame_ready=1 -> frame_bits = 49'h1FFFFFFFFFFFF one cycle after last pixel; all 0 -> 49'h0.
REQ-033 Only pixel (27,0) = 200, MIN_HITS=1 -> frame_bits = 49'h1 << 42; with MIN_HITS=2 -> 49'h0.
REQ-034 frame_ready=0 through two full frames -> first frame held unchanged, pix_ready=0 after second frame's last pixel, drops to IDLE after one handshake, second frame presented next.
REQ-035 pix_sof at pixel 300 of a frame -> sof_err pulse, following 783 pixels form a complete frame, no output for the aborted one.
REQ-036 5 pixels with pix_sof=0 after reset -> drop_cnt = 5, no state change; then normal frame completes.
REQ-037 rst_n low at pixel 500 -> all outputs 0; next full frame yields correct frame_bits.
